// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between AGEX and WB.
// Runs one load/store at a time over a valid/ready data port and registers results into the MEM latch.
module mem_stage #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int INSTBITS  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_ld,
  input  logic                 in_is_st,
  input  logic [1:0]           in_size,
  input  logic                 in_unsigned,
  input  logic [DBITS-1:0]     in_addr,
  input  logic [DBITS-1:0]     in_st_data,
  input  logic                 in_wr_reg,
  input  logic [REGNOBITS-1:0] in_wregno,
  input  logic [DBITS-1:0]     in_regval,
  input  logic [DBITS-1:0]     in_pc,
  input  logic [INSTBITS-1:0]  in_inst,
  input  logic [DBITS-1:0]     in_inst_count,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic                 dmem_req_we,
  output logic [DBITS-1:0]     dmem_req_addr,
  output logic [DBITS-1:0]     dmem_req_wdata,
  output logic [3:0]           dmem_req_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [DBITS-1:0]     dmem_rsp_rdata,
  output logic                 out_valid,
  output logic                 out_wr_reg,
  output logic [REGNOBITS-1:0] out_wregno,
  output logic [DBITS-1:0]     out_regval,
  output logic [DBITS-1:0]     out_pc,
  output logic [INSTBITS-1:0]  out_inst,
  output logic [DBITS-1:0]     out_inst_count,
  output logic                 out_misaligned,
  output logic                 ld_pending,
  output logic [REGNOBITS-1:0] ld_pending_regno
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 ld_q, ld_d;
  logic                 st_q, st_d;
  logic                 uns_q, uns_d;
  logic                 wr_reg_q, wr_reg_d;
  logic [1:0]           size_q, size_d;
  logic [DBITS-1:0]     addr_q, addr_d;
  logic [DBITS-1:0]     st_data_q, st_data_d;
  logic [DBITS-1:0]     regval_q, regval_d;
  logic [DBITS-1:0]     pc_q, pc_d;
  logic [DBITS-1:0]     inst_count_q, inst_count_d;
  logic [REGNOBITS-1:0] wregno_q, wregno_d;
  logic [INSTBITS-1:0]  inst_q, inst_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_wr_reg_q, out_wr_reg_d;
  logic                 out_misaligned_q, out_misaligned_d;
  logic [REGNOBITS-1:0] out_wregno_q, out_wregno_d;
  logic [DBITS-1:0]     out_regval_q, out_regval_d;
  logic [DBITS-1:0]     out_pc_q, out_pc_d;
  logic [INSTBITS-1:0]  out_inst_q, out_inst_d;
  logic [DBITS-1:0]     out_inst_count_q, out_inst_count_d;

  logic                 in_mem_op;
  logic                 in_misaligned;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [DBITS-1:0]     ld_data;

  assign in_mem_op     = in_is_ld | in_is_st;
  assign in_misaligned = (in_size == 2'd1) ? in_addr[0]
                                           : (in_size[1] & (in_addr[1:0] != 2'b00));

  // Lane selection and extension of the returned word for the captured load.
  always_comb begin
    ld_byte = dmem_rsp_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = dmem_rsp_rdata[15:8];
      2'd2:    ld_byte = dmem_rsp_rdata[23:16];
      2'd3:    ld_byte = dmem_rsp_rdata[31:24];
      default: ld_byte = dmem_rsp_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? dmem_rsp_rdata[31:16] : dmem_rsp_rdata[15:0];
    case (size_q)
      2'd0:    ld_data = {{(DBITS-8){~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{(DBITS-16){~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = dmem_rsp_rdata;
    endcase
  end

  always_comb begin
    dmem_req_wdata = '0;
    dmem_req_wstrb = '0;
    if ((state_q == REQ) && st_q) begin
      case (size_q)
        2'd0: begin
          dmem_req_wdata = {(DBITS/8){st_data_q[7:0]}};
          dmem_req_wstrb = 4'b0001 << addr_q[1:0];
        end
        2'd1: begin
          dmem_req_wdata = {(DBITS/16){st_data_q[15:0]}};
          dmem_req_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        end
        default: begin
          dmem_req_wdata = st_data_q;
          dmem_req_wstrb = 4'hF;
        end
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    ld_d             = ld_q;
    st_d             = st_q;
    uns_d            = uns_q;
    wr_reg_d         = wr_reg_q;
    size_d           = size_q;
    addr_d           = addr_q;
    st_data_d        = st_data_q;
    regval_d         = regval_q;
    pc_d             = pc_q;
    inst_count_d     = inst_count_q;
    wregno_d         = wregno_q;
    inst_d           = inst_q;
    out_valid_d      = 1'b0;
    out_wr_reg_d     = 1'b0;
    out_misaligned_d = 1'b0;
    out_wregno_d     = out_wregno_q;
    out_regval_d     = out_regval_q;
    out_pc_d         = out_pc_q;
    out_inst_d       = out_inst_q;
    out_inst_count_d = out_inst_count_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_mem_op && !in_misaligned) begin
            ld_d         = in_is_ld & ~in_is_st;
            st_d         = in_is_st;
            uns_d        = in_unsigned;
            wr_reg_d     = in_wr_reg;
            size_d       = in_size;
            addr_d       = in_addr;
            st_data_d    = in_st_data;
            regval_d     = in_regval;
            pc_d         = in_pc;
            inst_count_d = in_inst_count;
            wregno_d     = in_wregno;
            inst_d       = in_inst;
            state_d      = REQ;
          end else begin
            // Non-memory ops and faulting accesses both retire after a single cycle.
            out_valid_d      = 1'b1;
            out_wr_reg_d     = ~in_mem_op & in_wr_reg & (in_wregno != '0);
            out_misaligned_d = in_mem_op;
            out_wregno_d     = in_wregno;
            out_regval_d     = in_regval;
            out_pc_d         = in_pc;
            out_inst_d       = in_inst;
            out_inst_count_d = in_inst_count;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          if (st_q) begin
            out_valid_d      = 1'b1;
            out_wregno_d     = wregno_q;
            out_regval_d     = regval_q;
            out_pc_d         = pc_q;
            out_inst_d       = inst_q;
            out_inst_count_d = inst_count_q;
            state_d          = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          out_valid_d      = 1'b1;
          out_wr_reg_d     = wr_reg_q & (wregno_q != '0);
          out_wregno_d     = wregno_q;
          out_regval_d     = ld_data;
          out_pc_d         = pc_q;
          out_inst_d       = inst_q;
          out_inst_count_d = inst_count_q;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      ld_q             <= 1'b0;
      st_q             <= 1'b0;
      uns_q            <= 1'b0;
      wr_reg_q         <= 1'b0;
      size_q           <= '0;
      addr_q           <= '0;
      st_data_q        <= '0;
      regval_q         <= '0;
      pc_q             <= '0;
      inst_count_q     <= '0;
      wregno_q         <= '0;
      inst_q           <= '0;
      out_valid_q      <= 1'b0;
      out_wr_reg_q     <= 1'b0;
      out_misaligned_q <= 1'b0;
      out_wregno_q     <= '0;
      out_regval_q     <= '0;
      out_pc_q         <= '0;
      out_inst_q       <= '0;
      out_inst_count_q <= '0;
    end else begin
      state_q          <= state_d;
      ld_q             <= ld_d;
      st_q             <= st_d;
      uns_q            <= uns_d;
      wr_reg_q         <= wr_reg_d;
      size_q           <= size_d;
      addr_q           <= addr_d;
      st_data_q        <= st_data_d;
      regval_q         <= regval_d;
      pc_q             <= pc_d;
      inst_count_q     <= inst_count_d;
      wregno_q         <= wregno_d;
      inst_q           <= inst_d;
      out_valid_q      <= out_valid_d;
      out_wr_reg_q     <= out_wr_reg_d;
      out_misaligned_q <= out_misaligned_d;
      out_wregno_q     <= out_wregno_d;
      out_regval_q     <= out_regval_d;
      out_pc_q         <= out_pc_d;
      out_inst_q       <= out_inst_d;
      out_inst_count_q <= out_inst_count_d;
    end
  end

  // in_ready is gated by reset so that every output reads 0 while reset is held.
  assign in_ready         = (state_q == IDLE) & reset;
  assign dmem_req_valid   = (state_q == REQ);
  assign dmem_req_we      = (state_q == REQ) & st_q;
  assign dmem_req_addr    = (state_q == REQ) ? {addr_q[DBITS-1:2], 2'b00} : '0;
  assign ld_pending       = (state_q != IDLE) & ld_q & wr_reg_q & (wregno_q != '0);
  assign ld_pending_regno = ld_pending ? wregno_q : '0;

  assign out_valid      = out_valid_q;
  assign out_wr_reg     = out_wr_reg_q;
  assign out_wregno     = out_wregno_q;
  assign out_regval     = out_regval_q;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign out_inst_count = out_inst_count_q;
  assign out_misaligned = out_misaligned_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between AGEX and WB.
- Accepts one instruction at a time from the AGEX latch and performs loads/stores over a valid/ready data-memory interface with variable latency.
- Aligns and extends load data, then registers the result into the MEM latch that WB consumes.
- Back-pressures AGEX while a memory transaction is outstanding, and exports a pending-load indication to DE for hazard stalls.

Parameters:
- DBITS, 32, data/address width
- REGNOBITS, 5, register-number width
- INSTBITS, 32, instruction width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- in_valid  in  1  AGEX latch holds a real instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_is_ld / in_is_st  in  1 each  load / store
- in_size  in  2  0=byte, 1=half, 2=word (3 treated as word)
- in_unsigned  in  1  zero-extend load
- in_addr  in  DBITS  effective address from AGEX
- in_st_data  in  DBITS  store data (low bits used)
- in_wr_reg  in  1  writes a register
- in_wregno  in  REGNOBITS  destination register
- in_regval  in  DBITS  ALU result for non-loads
- in_pc, in_inst, in_inst_count  in  DBITS/INSTBITS/DBITS  bookkeeping
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  store
- dmem_req_addr  out  DBITS  word-aligned address ({in_addr[DBITS-1:2],2'b00})
- dmem_req_wdata  out  DBITS  replicated store data
- dmem_req_wstrb  out  4  byte enables
- dmem_rsp_valid  in  1  load data returned
- dmem_rsp_rdata  in  DBITS  raw word
- out_valid, out_wr_reg, out_wregno, out_regval, out_pc, out_inst, out_inst_count  out  MEM latch to WB
- out_misaligned  out  1  access fault flag
- ld_pending  out  1  load in flight
- ld_pending_regno  out  REGNOBITS  its destination

Behaviour:
- Reset asserted: all outputs 0, FSM=IDLE. Asserting reset mid-transaction abandons it; no response is consumed afterwards.
- FSM states: IDLE, REQ, WAIT. in_ready = (state==IDLE).
- IDLE, in_valid, no ld/st: at the next edge, latch the out_* fields with out_regval=in_regval; out_valid=1 for exactly one cycle. Latency is 1.
- IDLE, in_valid, ld/st, aligned: capture all fields; go to REQ.
- REQ: dmem_req_valid=1 with fields held stable until dmem_req_ready.
  - Store handshake: latch the MEM latch with out_wr_reg=0; go to IDLE.
  - Load handshake: go to WAIT.
- WAIT: on dmem_rsp_valid, extract the data, latch the MEM latch, go to IDLE.
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Extension: sign-extend unless in_unsigned.
- dmem_rsp_valid outside WAIT is ignored. A response arrives at least 1 cycle after acceptance.
- Minimum latency: store 2 cycles, load 3 cycles.
- Store encoding:
  - byte: wdata={4{b}}, wstrb=4'b0001<<addr[1:0]
  - half: wdata={2{h}}, wstrb=4'b0011<<{addr[1],1'b0}
  - word: wstrb=4'hF
  - dmem_req_wdata/wstrb are 0 when not a store.
- Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0):
  - No memory request.
  - 1-cycle result with out_valid=1, out_misaligned=1, out_wr_reg=0.
- out_wr_reg is always 0 when out_wregno==0.
- Every cycle without a completion is a bubble: out_valid=0, out_wr_reg=0, out_misaligned=0; other out_* fields hold their values.
- ld_pending=1 in REQ/WAIT for a load with wr_reg=1 and regno!=0; ld_pending_regno is valid only while ld_pending=1.
- in_valid=0 in IDLE: stay IDLE, emit a bubble.

Test Plan:
- ALU op: in_wr_reg=1, wregno=5, regval=0x1234 -> next cycle out_valid=1, out_wregno=5, out_regval=0x1234; following cycle out_valid=0.
- Signed byte load: addr=0x103, memory returns 0x80FFFF7F two cycles after req_ready -> out_regval=0xFFFFFF80; in_ready=0 throughout; ld_pending=1 with the correct regno.
- Unsigned half load: addr=0x102, rdata=0xBEEF1234 -> 0x0000BEEF; the same load with in_unsigned=0 -> 0xFFFFBEEF.
- Store half: addr=0x202, data=0x0000ABCD, req_ready held low 3 cycles -> req fields stable; wdata=0xABCDABCD, wstrb=0xC, we=1; then out_valid=1 with out_wr_reg=0.
- Misaligned word load at 0x101 -> dmem_req_valid never asserts; out_misaligned=1, out_wr_reg=0 next cycle. Load to x0 -> out_wr_reg=0, ld_pending=0.
- Reset pulsed low while in WAIT, then a stray rsp_valid -> all outputs 0, state IDLE, no spurious out_valid.
